// File: rtl/pvt_measure_scheduler_if.sv
// Monitor control plane and result handshake of the PVT measurement scheduler.
// master = scheduler side, slave = monitors plus result consumer.
interface pvt_measure_scheduler_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]           mon_start;
    logic [NUM_CH*CNT_WIDTH-1:0] mon_cnt;
    logic                        res_valid;
    logic                        res_ready;
    logic [CH_W-1:0]             res_ch;
    logic [CNT_WIDTH-1:0]        res_data;
    logic                        res_sat;

    modport master (
        output mon_start,
        input  mon_cnt,
        output res_valid,
        input  res_ready,
        output res_ch,
        output res_data,
        output res_sat
    );

    modport slave (
        input  mon_start,
        output mon_cnt,
        input  res_valid,
        output res_ready,
        input  res_ch,
        input  res_data,
        input  res_sat
    );
endinterface

// File: rtl/pvt_measure_scheduler.sv
// Round-robin sequencer for delay-chain PVT monitors: starts each masked
// channel, averages 2^LOG2_AVG samples and hands one result per channel out.
module pvt_measure_scheduler #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int START_CYC = 2,
    parameter int WAIT_CYC  = 300,
    parameter int LOG2_AVG  = 2,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  single_shot,
    input  logic [NUM_CH-1:0]     ch_mask,
    output logic                  busy,
    output logic                  sweep_done,
    pvt_measure_scheduler_if.master bus
);
    localparam int ACC_W   = CNT_WIDTH + LOG2_AVG;
    localparam int IDX_W   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int CYC_MAX = (START_CYC > WAIT_CYC) ? START_CYC : WAIT_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'((1 << LOG2_AVG) - 1);
    localparam logic [CYC_W-1:0]  START_LAST = CYC_W'(START_CYC - 1);
    localparam logic [CYC_W-1:0]  WAIT_LAST  = CYC_W'(WAIT_CYC - 1);
    localparam logic [NUM_CH-1:0] ONE        = NUM_CH'(1);

    typedef enum logic [2:0] {
        IDLE, START, WAIT, SAMPLE, OUTPUT
    } state_e;

    state_e               state_q;
    logic [NUM_CH-1:0]    mask_q;
    logic [NUM_CH-1:0]    mon_start_q;
    logic                 cont_q;
    logic [CH_W-1:0]      ch_q;
    logic [CYC_W-1:0]     cyc_q;
    logic [IDX_W-1:0]     idx_q;
    logic [ACC_W-1:0]     acc_q;
    logic                 sat_q;
    logic                 res_valid_q;
    logic [CH_W-1:0]      res_ch_q;
    logic [CNT_WIDTH-1:0] res_data_q;
    logic                 res_sat_q;
    logic                 busy_q;
    logic                 done_q;

    // Returns {found, index} of the lowest set bit at or above 'from'.
    function automatic logic [CH_W:0] first_set(
        input logic [NUM_CH-1:0] m,
        input int                from
    );
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i >= from && m[i]) begin
                r = {1'b1, CH_W'(i)};
            end
        end
        return r;
    endfunction

    logic [CNT_WIDTH-1:0] slice;
    logic                 slice_sat;
    logic [ACC_W-1:0]     acc_sum;
    logic [CNT_WIDTH-1:0] avg;
    logic [CH_W:0]        nxt_ch;
    logic [CH_W:0]        new_ch;

    always_comb begin
        slice = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                slice = bus.mon_cnt[k*CNT_WIDTH +: CNT_WIDTH];
            end
        end
        slice_sat = &slice;
        acc_sum   = acc_q + ACC_W'(slice);
        avg       = CNT_WIDTH'(acc_sum >> LOG2_AVG);
        nxt_ch    = first_set(mask_q, int'(ch_q) + 1);
        new_ch    = first_set(ch_mask, 0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            mon_start_q <= '0;
            cont_q      <= 1'b0;
            ch_q        <= '0;
            cyc_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            res_sat_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if ((enable || single_shot) && new_ch[CH_W]) begin
                        mask_q      <= ch_mask;
                        cont_q      <= enable;
                        ch_q        <= new_ch[CH_W-1:0];
                        mon_start_q <= ONE << new_ch[CH_W-1:0];
                        cyc_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    if (cyc_q == START_LAST) begin
                        cyc_q       <= '0;
                        mon_start_q <= '0;
                        state_q     <= WAIT;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (cyc_q == WAIT_LAST) begin
                        cyc_q   <= '0;
                        state_q <= SAMPLE;
                    end else begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    acc_q <= acc_sum;
                    sat_q <= sat_q | slice_sat;
                    if (idx_q == LAST_IDX) begin
                        res_valid_q <= 1'b1;
                        res_ch_q    <= ch_q;
                        res_data_q  <= avg;
                        res_sat_q   <= sat_q | slice_sat;
                        state_q     <= OUTPUT;
                    end else begin
                        idx_q       <= idx_q + 1'b1;
                        mon_start_q <= ONE << ch_q;
                        state_q     <= START;
                    end
                end
                OUTPUT: begin
                    // After the handshake, one cycle is spent choosing what follows.
                    if (res_valid_q) begin
                        if (bus.res_ready) begin
                            res_valid_q <= 1'b0;
                            acc_q       <= '0;
                            idx_q       <= '0;
                            sat_q       <= 1'b0;
                        end
                    end else if (nxt_ch[CH_W]) begin
                        ch_q        <= nxt_ch[CH_W-1:0];
                        mon_start_q <= ONE << nxt_ch[CH_W-1:0];
                        state_q     <= START;
                    end else begin
                        done_q <= 1'b1;
                        if (cont_q && enable && new_ch[CH_W]) begin
                            mask_q      <= ch_mask;
                            ch_q        <= new_ch[CH_W-1:0];
                            mon_start_q <= ONE << new_ch[CH_W-1:0];
                            state_q     <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mon_start = mon_start_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_sat   = res_sat_q;
    assign busy          = busy_q;
    assign sweep_done    = done_q;
endmodule

// File: tb/tb_pvt_measure_scheduler.sv
// Directed bench for pvt_measure_scheduler (START_CYC=2, WAIT_CYC=8, 4 samples).
// Behavioural monitor stubs present a per-channel sample sequence on mon_cnt.
module tb_pvt_measure_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       single_shot = 1'b0;
    logic [3:0] ch_mask = 4'b0;
    logic       busy;
    logic       sweep_done;

    int checks = 0;
    int errors = 0;

    pvt_measure_scheduler_if #(.NUM_CH(4), .CNT_WIDTH(8)) bus ();

    pvt_measure_scheduler #(
        .NUM_CH(4), .CNT_WIDTH(8), .START_CYC(2), .WAIT_CYC(8), .LOG2_AVG(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .single_shot(single_shot),
        .ch_mask(ch_mask),
        .busy(busy),
        .sweep_done(sweep_done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Monitor stubs: each rising mon_start loads that channel's next sample.
    logic [7:0]  seq [4][4];
    logic [1:0]  sidx [4];
    logic [3:0]  ms_prev;
    logic [31:0] cnt_r;
    logic        stub_clr = 1'b1;

    assign bus.mon_cnt = cnt_r;

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (stub_clr) begin
                sidx[c] <= 2'd0;
            end else if (bus.mon_start[c] && !ms_prev[c]) begin
                cnt_r[c*8 +: 8] <= seq[c][sidx[c]];
                sidx[c]         <= sidx[c] + 2'd1;
            end
        end
        if (stub_clr) cnt_r <= 32'd0;
        ms_prev <= bus.mon_start;
    end

    int   bad_onehot = 0;
    int   bad13 = 0;
    int   done_cnt = 0;
    logic watch13 = 1'b0;

    always @(negedge clk) begin
        if ($countones(bus.mon_start) > 1) bad_onehot <= bad_onehot + 1;
        if (watch13 && (bus.mon_start[1] || bus.mon_start[3])) bad13 <= bad13 + 1;
        if (sweep_done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        int              ch;
        logic [3:0][7:0] s;
        int              data;
        int              sat;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_single();
        single_shot = 1'b1;
        step();
        single_shot = 1'b0;
    endtask

    task automatic clr_stub();
        stub_clr = 1'b1;
        step();
        stub_clr = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!bus.res_valid && n < 200) begin
            step();
            n++;
        end
        if (!bus.res_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: res_valid got 0 expected 1 within 200 cycles", name);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!sweep_done && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (!sweep_done) begin
            errors++;
            $display("FAIL %s: sweep_done got 0 expected 1 within 200 cycles", name);
        end
    endtask

    task automatic set_seq(input int ch, input logic [3:0][7:0] s);
        for (int k = 0; k < 4; k++) seq[ch][k] = s[k];
    endtask

    task automatic run_vec(input int v);
        int n;
        set_seq(vecs[v].ch, vecs[v].s);
        ch_mask = 4'b0001 << vecs[v].ch;
        clr_stub();
        pulse_single();
        wait_valid($sformatf("vec%0d_wait", v), n);
        chk($sformatf("vec%0d_latency", v), n, 44);
        chk($sformatf("vec%0d_ch", v), int'(bus.res_ch), vecs[v].ch);
        chk($sformatf("vec%0d_data", v), int'(bus.res_data), vecs[v].data);
        chk($sformatf("vec%0d_sat", v), int'(bus.res_sat), vecs[v].sat);
        wait_done($sformatf("vec%0d_done", v));
        chk($sformatf("vec%0d_idle", v), int'(busy), 0);
    endtask

    initial begin
        int n;
        int d0;
        int act;

        vecs[0] = '{ch: 1, s: {8'd14, 8'd12, 8'd11, 8'd10}, data: 11, sat: 0};
        vecs[1] = '{ch: 3, s: {8'd1, 8'd0, 8'd0, 8'd255}, data: 64, sat: 1};
        vecs[2] = '{ch: 3, s: {8'd1, 8'd1, 8'd1, 8'd1}, data: 1, sat: 0};
        vecs[3] = '{ch: 0, s: {8'd255, 8'd255, 8'd255, 8'd255}, data: 255, sat: 1};
        vecs[4] = '{ch: 2, s: {8'd0, 8'd0, 8'd0, 8'd3}, data: 0, sat: 0};
        vecs[5] = '{ch: 0, s: {8'd6, 8'd7, 8'd7, 8'd7}, data: 6, sat: 0};
        vecs[6] = '{ch: 1, s: {8'd254, 8'd254, 8'd254, 8'd254}, data: 254, sat: 0};
        bus.res_ready = 1'b1;

        #2;
        chk("rst_mon_start", int'(bus.mon_start), 0);
        chk("rst_valid", int'(bus.res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(sweep_done), 0);
        step();
        step();
        rst = 1'b0;
        stub_clr = 1'b0;
        step();

        // Two-channel sweep timing, mask 0101
        set_seq(0, {8'd10, 8'd10, 8'd10, 8'd10});
        set_seq(2, {8'd20, 8'd20, 8'd20, 8'd20});
        ch_mask = 4'b0101;
        clr_stub();
        watch13 = 1'b1;
        d0 = done_cnt;
        pulse_single();
        wait_valid("sweep_ch0_wait", n);
        chk("sweep_ch0_latency", n, 44);
        chk("sweep_ch0_ch", int'(bus.res_ch), 0);
        chk("sweep_ch0_data", int'(bus.res_data), 10);
        step();
        chk("sweep_valid_drop", int'(bus.res_valid), 0);
        wait_valid("sweep_ch2_wait", n);
        chk("sweep_ch2_latency", n, 45);
        chk("sweep_ch2_ch", int'(bus.res_ch), 2);
        chk("sweep_ch2_data", int'(bus.res_data), 20);
        step();
        chk("sweep_done_early", int'(sweep_done), 0);
        step();
        chk("sweep_done_pulse", int'(sweep_done), 1);
        chk("sweep_busy_after", int'(busy), 0);
        step();
        chk("sweep_done_width", int'(sweep_done), 0);
        watch13 = 1'b0;
        chk("sweep_no_ch1_ch3", bad13, 0);
        chk("sweep_done_count", done_cnt - d0, 1);

        for (int v = 0; v < 7; v++) run_vec(v);

        // Backpressure on channel 0, then channel 1 follows
        set_seq(0, {8'd5, 8'd5, 8'd5, 8'd5});
        set_seq(1, {8'd6, 8'd6, 8'd6, 8'd6});
        ch_mask = 4'b0011;
        bus.res_ready = 1'b0;
        clr_stub();
        pulse_single();
        wait_valid("bp_wait", n);
        act = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!(bus.res_valid && bus.res_ch == 2'd0 && bus.res_data == 8'd5
                  && bus.mon_start == 4'd0)) act++;
        end
        chk("bp_stable_cycles_bad", act, 0);
        bus.res_ready = 1'b1;
        step();
        chk("bp_handshake_valid", int'(bus.res_valid), 0);
        chk("bp_handshake_start", int'(bus.mon_start), 0);
        step();
        chk("bp_next_start", int'(bus.mon_start), 2);
        wait_valid("bp_ch1_wait", n);
        chk("bp_ch1_ch", int'(bus.res_ch), 1);
        chk("bp_ch1_data", int'(bus.res_data), 6);
        wait_done("bp_done");

        // Continuous mode on channel 3
        set_seq(3, {8'd9, 8'd9, 8'd9, 8'd9});
        ch_mask = 4'b1000;
        clr_stub();
        enable = 1'b1;
        wait_valid("cont1_wait", n);
        chk("cont1_ch", int'(bus.res_ch), 3);
        chk("cont1_data", int'(bus.res_data), 9);
        wait_done("cont1_done");
        chk("cont1_restart_busy", int'(busy), 1);
        chk("cont1_restart_start", int'(bus.mon_start), 8);
        wait_valid("cont2_wait", n);
        chk("cont2_data", int'(bus.res_data), 9);
        wait_done("cont2_done");
        for (int i = 0; i < 5; i++) step();
        chk("cont3_in_wait", int'(bus.mon_start == 4'd0 && busy), 1);
        enable = 1'b0;
        wait_valid("cont3_wait", n);
        chk("cont3_ch", int'(bus.res_ch), 3);
        chk("cont3_data", int'(bus.res_data), 9);
        wait_done("cont3_done");
        chk("cont3_idle", int'(busy), 0);
        act = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy || bus.mon_start != 4'd0) act++;
        end
        chk("cont_stays_idle", act, 0);

        // single_shot with an empty mask
        ch_mask = 4'b0000;
        d0 = done_cnt;
        pulse_single();
        act = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || bus.mon_start != 4'd0 || bus.res_valid) act++;
            step();
        end
        chk("mask0_activity", act, 0);
        chk("mask0_done", done_cnt - d0, 0);

        // Reset during WAIT after one saturated sample
        set_seq(2, {8'd255, 8'd255, 8'd255, 8'd255});
        ch_mask = 4'b0100;
        clr_stub();
        pulse_single();
        for (int i = 0; i < 14; i++) step();
        rst = 1'b1;
        #1;
        chk("rstw_mon_start", int'(bus.mon_start), 0);
        chk("rstw_valid", int'(bus.res_valid), 0);
        chk("rstw_busy", int'(busy), 0);
        chk("rstw_done", int'(sweep_done), 0);
        step();
        rst = 1'b0;
        set_seq(2, {8'd7, 8'd6, 8'd5, 8'd4});
        clr_stub();
        act = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy || bus.mon_start != 4'd0) act++;
        end
        chk("rstw_idle_after", act, 0);
        pulse_single();
        wait_valid("rstw_fresh_wait", n);
        chk("rstw_fresh_latency", n, 44);
        chk("rstw_fresh_data", int'(bus.res_data), 5);
        chk("rstw_fresh_sat", int'(bus.res_sat), 0);
        wait_done("rstw_fresh_done");

        // Reset while mon_start is high
        pulse_single();
        chk("rsts_start_high", int'(bus.mon_start), 4);
        rst = 1'b1;
        #1;
        chk("rsts_mon_start", int'(bus.mon_start), 0);
        chk("rsts_busy", int'(busy), 0);
        step();
        rst = 1'b0;
        step();

        chk("onehot_violations", bad_onehot, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
